bcd_seg_encoder: RTL

BCD_SEG_ENCODER -- requirements
Module: bcd_seg_encoder

---
 rtl/bcd_seg_encoder_if.sv | 28 ++
 rtl/bcd_seg_encoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_seg_encoder_if.sv
// Value/display bundle of the two-digit BCD 7-segment encoder.
// master drives value_valid/value; slave returns ready, both7seg, ovf, done.
interface bcd_seg_encoder_if;
   logic        value_valid;
   logic [7:0]  value;
   logic        ready;
   logic [13:0] both7seg;
   logic        ovf;
   logic        done;

   modport master (
      output value_valid,
      output value,
      input  ready,
      input  both7seg,
      input  ovf,
      input  done
   );

   modport slave (
      input  value_valid,
      input  value,
      output ready,
      output both7seg,
      output ovf,
      output done
   );
endinterface

// File: rtl/bcd_seg_encoder.sv
// Converts an 8-bit binary value to two registered 7-segment digits
// via a sequential double-dabble (8 shift cycles), with overflow dash.
// Ports: clk, rst (async, active-high), bus (slave): value_valid/value in,
//        ready/both7seg[13:7]=tens,[6:0]=ones/ovf/done out.
module bcd_seg_encoder #(
   parameter bit BLANK_LEADING = 1'b1,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   bcd_seg_encoder_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;

   localparam logic [6:0]  DASH  = 7'h40;
   localparam logic [6:0]  BLANK = 7'h00;
   localparam logic [13:0] POL   = {14{ACTIVE_LOW}};
   localparam logic [13:0] OFF14 = POL;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = BLANK;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic [19:0] sr;
   logic [19:0] sr_adj;
   logic [13:0] seg_nxt;
   logic        ovf_nxt;
   logic        ready_q;
   logic [13:0] seg_q;
   logic        ovf_q;
   logic        done_q;

   logic [3:0]  hund;
   logic [3:0]  tens;
   logic [3:0]  ones;
   logic [6:0]  tens_seg;

   assign hund = sr[19:16];
   assign tens = sr[15:12];
   assign ones = sr[11:8];

   // BCD columns sit above the binary byte that is shifted out the top.
   always_comb begin
      sr_adj = {add3(sr[19:16]),
                add3(sr[15:12]),
                add3(sr[11:8]),
                sr[7:0]};
   end

   always_comb begin
      tens_seg = seg_code(tens);
      if (BLANK_LEADING && tens == 4'd0) begin
         tens_seg = BLANK;
      end
      if (hund != 4'd0) begin
         seg_nxt = {DASH, DASH} ^ POL;
         ovf_nxt = 1'b1;
      end else begin
         seg_nxt = {tens_seg, seg_code(ones)} ^ POL;
         ovf_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         sr      <= 20'd0;
         ready_q <= 1'b1;
         seg_q   <= OFF14;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.value_valid && ready_q) begin
                  sr      <= {12'd0, bus.value};
                  cnt     <= 3'd0;
                  ready_q <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= sr_adj << 1;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               seg_q   <= seg_nxt;
               ovf_q   <= ovf_nxt;
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.both7seg = seg_q;
   assign bus.ovf      = ovf_q;
   assign bus.done     = done_q;

endmodule
